// File: rtl/cam_capture_if.sv
// -----------------------------------------------------------------------------
// cam_capture_if
// Bundles the sensor-side byte stream and the frame-buffer write port of
// cam_capture. The clock and reset stay outside as plain ports.
//
//   CamVsync  : frame sync, high = vertical blanking
//   CamHsync  : line valid (HREF), high = data byte present
//   CamData   : sensor byte bus
//   SW0       : capture enable, looked at only at frame start
//   PixWe     : one-cycle frame-buffer write strobe
//   PixAddr   : write address, y*H_PIX + x
//   PixData   : RGB565 pixel {first byte, second byte}
//   FrameDone : one-cycle pulse at the end of a captured frame
//   LineErr   : sticky malformed-line flag for the current frame
//   Capturing : high while a frame is being captured
//
// slave  = the capture block, master = whatever drives the sensor side and
// consumes the write port.
// -----------------------------------------------------------------------------
interface cam_capture_if #(
    parameter int ADDR_W = 19
);
    logic              CamVsync;
    logic              CamHsync;
    logic [7:0]        CamData;
    logic              SW0;
    logic              PixWe;
    logic [ADDR_W-1:0] PixAddr;
    logic [15:0]       PixData;
    logic              FrameDone;
    logic              LineErr;
    logic              Capturing;

    modport slave (
        input  CamVsync, CamHsync, CamData, SW0,
        output PixWe, PixAddr, PixData, FrameDone, LineErr, Capturing
    );

    modport master (
        output CamVsync, CamHsync, CamData, SW0,
        input  PixWe, PixAddr, PixData, FrameDone, LineErr, Capturing
    );
endinterface

// File: rtl/cam_capture.sv
// -----------------------------------------------------------------------------
// cam_capture
// OV7670-style capture stage. Registers the sensor port on PCLK, pairs bytes
// into RGB565 pixels and writes them to the frame buffer at linear addresses
// (line base + x). Flags frame completion and lines whose byte count differs
// from 2*H_PIX.
//
// Ports:
//   PCLK  : sensor pixel clock, sole clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : cam_capture_if.slave (sensor inputs, SW0, frame-buffer outputs)
//
// Parameters: H_PIX active pixels per line, V_LINES active lines per frame,
// ADDR_W frame-buffer address width (2**ADDR_W >= H_PIX*V_LINES).
// -----------------------------------------------------------------------------
module cam_capture #(
    parameter int H_PIX   = 640,
    parameter int V_LINES = 480,
    parameter int ADDR_W  = 19
) (
    input  logic          PCLK,
    input  logic          RST_N,
    cam_capture_if.slave  bus
);

    localparam int X_W = $clog2(H_PIX + 1);
    localparam int Y_W = $clog2(V_LINES + 1);
    localparam int B_W = $clog2(2 * H_PIX + 2);

    localparam logic [X_W-1:0]    X_END     = X_W'(H_PIX);
    localparam logic [Y_W-1:0]    Y_END     = Y_W'(V_LINES);
    localparam logic [B_W-1:0]    B_LINE    = B_W'(2 * H_PIX);
    localparam logic [B_W-1:0]    B_SAT     = B_W'(2 * H_PIX + 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIX);

    typedef enum logic {
        IDLE,
        CAPTURE
    } stateT;

    stateT             state;

    // Input stage
    logic              vsQ, vsQ2;
    logic              hsQ, hsQ2;
    logic [7:0]        dQ;
    logic              phase;      // byte phase of the byte currently in dQ
    logic [7:0]        hiByte;

    // Pixel / line bookkeeping
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [B_W-1:0]    byteCnt;
    logic [ADDR_W-1:0] lineBase;

    logic frameStart, frameEnd, lineEnd;

    assign frameStart = vsQ2 & ~vsQ;
    assign frameEnd   = ~vsQ2 & vsQ;
    assign lineEnd    = hsQ2 & ~hsQ;

    // NOTE: clocked state uses non-blocking assignments so every register in
    // this block sees the values from before the edge, whatever the order of
    // the statements.
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            vsQ    <= 1'b0;
            vsQ2   <= 1'b0;
            hsQ    <= 1'b0;
            hsQ2   <= 1'b0;
            dQ     <= '0;
            phase  <= 1'b0;
            hiByte <= '0;
        end else begin
            vsQ    <= bus.CamVsync;
            vsQ2   <= vsQ;
            hsQ    <= bus.CamHsync;
            hsQ2   <= hsQ;
            dQ     <= bus.CamData;
            phase  <= hsQ ? ~phase : 1'b0;
            if (hsQ && !phase) begin
                hiByte <= dQ;
            end
        end
    end

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            x             <= '0;
            y             <= '0;
            byteCnt       <= '0;
            lineBase      <= '0;
            bus.PixWe     <= 1'b0;
            bus.PixAddr   <= '0;
            bus.PixData   <= '0;
            bus.FrameDone <= 1'b0;
            bus.LineErr   <= 1'b0;
            bus.Capturing <= 1'b0;
        end else begin
            // NOTE: strobes default low here so each one lasts exactly one
            // cycle; PixAddr/PixData have no default and therefore hold.
            bus.PixWe     <= 1'b0;
            bus.FrameDone <= 1'b0;

            case (state)
                IDLE: begin
                    if (frameStart && bus.SW0) begin
                        state         <= CAPTURE;
                        bus.Capturing <= 1'b1;
                        x             <= '0;
                        y             <= '0;
                        byteCnt       <= '0;
                        lineBase      <= '0;
                        bus.LineErr   <= 1'b0;
                    end
                end

                CAPTURE: begin
                    if (frameStart) begin
                        // Vsync high was missed: start over without FrameDone.
                        x           <= '0;
                        y           <= '0;
                        byteCnt     <= '0;
                        lineBase    <= '0;
                        bus.LineErr <= 1'b0;
                    end else begin
                        if (hsQ && !vsQ) begin
                            // Byte and pixel counters saturate just past the
                            // limits that matter, so long lines cannot wrap
                            // back into the valid range.
                            if (byteCnt != B_SAT) begin
                                byteCnt <= byteCnt + 1'b1;
                            end
                            if (phase && x != X_END) begin
                                x <= x + 1'b1;
                                if (y != Y_END) begin
                                    bus.PixWe   <= 1'b1;
                                    bus.PixAddr <= lineBase + ADDR_W'(x);
                                    bus.PixData <= {hiByte, dQ};
                                end
                            end
                        end

                        // A trailing odd byte is simply never paired.
                        if (lineEnd) begin
                            if (byteCnt != B_LINE) begin
                                bus.LineErr <= 1'b1;
                            end
                            byteCnt <= '0;
                            x       <= '0;
                            if (y != Y_END) begin
                                y        <= y + 1'b1;
                                lineBase <= lineBase + LINE_STEP;
                            end
                        end

                        if (frameEnd) begin
                            bus.FrameDone <= 1'b1;
                            bus.Capturing <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.Capturing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// -----------------------------------------------------------------------------
// tb_cam_capture
// Drives whole frames into cam_capture (H_PIX=4, V_LINES=2) and checks every
// frame-buffer write against an expected-write queue built from the byte
// stream: pixel p of line l is written at l*H+p with {byte 2p, byte 2p+1}
// whenever the frame was enabled and p<H, l<V.
// -----------------------------------------------------------------------------
module tb_cam_capture;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 8;

    logic PCLK  = 1'b0;
    logic RST_N = 1'b0;

    always #5 PCLK = ~PCLK;

    cam_capture_if #(.ADDR_W(AW)) bus ();

    cam_capture #(
        .H_PIX  (H),
        .V_LINES(V),
        .ADDR_W (AW)
    ) dut (
        .PCLK (PCLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    typedef struct {
        int addr;
        int data;
    } wrT;

    int  nChecks = 0;
    int  nFails  = 0;
    wrT  expQ[$];
    int  fdSeen  = 0;
    int  fdExp   = 0;
    bit  mCapture = 1'b0;
    bit  mErr     = 1'b0;
    int  mLine    = 0;

    bit          logging = 1'b0;
    int          logAddr[$];
    logic [15:0] logData[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every write strobe must match the oldest expected write.
    always @(negedge PCLK) begin : compare
        wrT w;
        if (!RST_N) begin
            expQ.delete();
        end else begin
            if (bus.FrameDone === 1'b1) fdSeen++;
            if (bus.PixWe !== 1'b0) begin
                if (logging) begin
                    logAddr.push_back(int'(bus.PixAddr));
                    logData.push_back(bus.PixData);
                end
                if (expQ.size() == 0) begin
                    check("write expected", 32'(expQ.size() != 0), 32'd1);
                end else begin
                    w = expQ.pop_front();
                    check("PixAddr", 32'(bus.PixAddr), w.addr);
                    check("PixData", 32'(bus.PixData), w.data);
                end
            end
        end
    end

    // Vsync falls; the block decides on SW0 two edges later, after which SW0
    // is changed (swAfter<0: random) to show it is ignored mid-frame.
    task automatic frameStart(input bit sw, input int swAfter);
        @(negedge PCLK);
        bus.SW0      = sw;
        bus.CamVsync = 1'b0;
        bus.CamHsync = 1'b0;
        mCapture = sw;
        if (sw) begin
            mErr  = 1'b0;
            mLine = 0;
        end
        repeat (3) @(negedge PCLK);
        check("Capturing after frame start", 32'(bus.Capturing), 32'(mCapture));
        bus.SW0 = (swAfter < 0) ? 1'($urandom_range(0, 1)) : 1'(swAfter);
    endtask

    // One HREF window of len bytes (base<0: random bytes, else base+i).
    // endVs raises vsync on the same cycle HREF drops. rstAt>=0 pulses reset
    // at that byte index for three cycles.
    task automatic sendLine(input int len, input int base, input bit endVs, input int rstAt);
        logic [7:0] cur;
        logic [7:0] prev;
        prev = 8'h00;
        for (int i = 0; i < len; i++) begin
            @(negedge PCLK);
            cur = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + i);
            bus.CamHsync = 1'b1;
            bus.CamData  = cur;
            if (i == rstAt + 3) RST_N = 1'b1;
            if (i == rstAt) begin
                RST_N    = 1'b0;
                mCapture = 1'b0;
                mErr     = 1'b0;
                #1;
                check("reset PixWe",     32'(bus.PixWe),     32'd0);
                check("reset PixAddr",   32'(bus.PixAddr),   32'd0);
                check("reset PixData",   32'(bus.PixData),   32'd0);
                check("reset FrameDone", 32'(bus.FrameDone), 32'd0);
                check("reset LineErr",   32'(bus.LineErr),   32'd0);
                check("reset Capturing", 32'(bus.Capturing), 32'd0);
            end
            if ((i % 2 == 1) && mCapture && mLine < V && (i / 2) < H) begin
                expQ.push_back('{addr: mLine * H + i / 2, data: int'({prev, cur})});
            end
            prev = cur;
        end
        @(negedge PCLK);
        bus.CamHsync = 1'b0;
        bus.CamData  = 8'($urandom_range(0, 255));
        if (endVs) bus.CamVsync = 1'b1;
        if (mCapture) begin
            if (len != 2 * H) mErr = 1'b1;
            mLine++;
        end
        if (!endVs) begin
            repeat (3) @(negedge PCLK);
            check("LineErr after line", 32'(bus.LineErr), 32'(mErr));
        end
    endtask

    // Vsync rises (unless the last line already raised it), optional HREF
    // activity inside blanking, then the per-frame checks.
    task automatic frameEnd(input bit alreadyHigh, input bit hrefInBlank);
        if (!alreadyHigh) begin
            @(negedge PCLK);
            bus.CamVsync = 1'b1;
        end
        if (mCapture) fdExp++;
        mCapture = 1'b0;
        repeat (3) @(negedge PCLK);
        if (hrefInBlank) begin
            for (int i = 0; i < 6; i++) begin
                @(negedge PCLK);
                bus.CamHsync = 1'b1;
                bus.CamData  = 8'($urandom_range(0, 255));
            end
            @(negedge PCLK);
            bus.CamHsync = 1'b0;
        end
        repeat (3) @(negedge PCLK);
        check("FrameDone count", 32'(fdSeen), 32'(fdExp));
        check("writes outstanding", 32'(expQ.size()), 32'd0);
        check("LineErr at frame end", 32'(bus.LineErr), 32'(mErr));
        check("Capturing after frame end", 32'(bus.Capturing), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bit sw;
        bit simul;
        int nl;
        int len;

        bus.CamVsync = 1'b1;
        bus.CamHsync = 1'b0;
        bus.CamData  = 8'h00;
        bus.SW0      = 1'b0;
        repeat (3) @(negedge PCLK);
        check("init PixWe",     32'(bus.PixWe),     32'd0);
        check("init PixAddr",   32'(bus.PixAddr),   32'd0);
        check("init FrameDone", 32'(bus.FrameDone), 32'd0);
        check("init Capturing", 32'(bus.Capturing), 32'd0);
        RST_N = 1'b1;
        repeat (3) @(negedge PCLK);

        // Basic frame: two lines of 0x00..0x0F.
        logging = 1'b1;
        frameStart(1'b1, 1);
        sendLine(8, 0, 1'b0, -1);
        sendLine(8, 8, 1'b0, -1);
        frameEnd(1'b0, 1'b0);
        logging = 1'b0;
        check("basic write count", 32'(logAddr.size()), 32'd8);
        check("basic addr[0]", 32'(logAddr[0]), 32'd0);
        check("basic data[0]", 32'(logData[0]), 32'h0001);
        check("basic data[3]", 32'(logData[3]), 32'h0607);
        check("basic addr[7]", 32'(logAddr[7]), 32'd7);
        check("basic data[7]", 32'(logData[7]), 32'h0E0F);
        check("basic FrameDone", 32'(fdSeen), 32'd1);
        check("basic LineErr", 32'(bus.LineErr), 32'd0);

        // Disabled at frame start, SW0 raised mid-frame: nothing happens.
        frameStart(1'b0, 1);
        sendLine(8, 0, 1'b0, -1);
        sendLine(8, 8, 1'b0, -1);
        frameEnd(1'b0, 1'b0);
        check("disabled frame FrameDone", 32'(fdSeen), 32'd1);
        frameStart(1'b1, 0);
        sendLine(8, 0, 1'b0, -1);
        sendLine(8, 8, 1'b0, -1);
        frameEnd(1'b0, 1'b0);

        // Malformed lines: 9 bytes then 6 bytes.
        logAddr.delete();
        logData.delete();
        logging = 1'b1;
        frameStart(1'b1, 1);
        sendLine(9, 32, 1'b0, -1);
        check("LineErr after 9-byte line", 32'(bus.LineErr), 32'd1);
        sendLine(6, 64, 1'b0, -1);
        frameEnd(1'b0, 1'b0);
        logging = 1'b0;
        check("odd frame write count", 32'(logAddr.size()), 32'd7);
        check("odd frame last addr", 32'(logAddr[6]), 32'd6);
        check("odd frame data[3]", 32'(logData[3]), 32'h2627);
        check("LineErr held after frame", 32'(bus.LineErr), 32'd1);
        frameStart(1'b1, 1);
        check("LineErr cleared at frame start", 32'(bus.LineErr), 32'd0);

        // Three lines, V=2: third line clipped; lines end with vsync rising.
        sendLine(8, -1, 1'b0, -1);
        sendLine(8, -1, 1'b0, -1);
        sendLine(8, -1, 1'b1, -1);
        frameEnd(1'b1, 1'b1);

        // Reset in the middle of line 1, released mid-frame.
        frameStart(1'b1, 1);
        sendLine(8, -1, 1'b0, -1);
        sendLine(8, -1, 1'b0, 3);
        sendLine(8, -1, 1'b0, -1);
        frameEnd(1'b0, 1'b0);
        logAddr.delete();
        logData.delete();
        logging = 1'b1;
        frameStart(1'b1, 1);
        sendLine(8, 16, 1'b0, -1);
        frameEnd(1'b0, 1'b0);
        logging = 1'b0;
        check("post-reset first addr", 32'(logAddr[0]), 32'd0);
        check("post-reset first data", 32'(logData[0]), 32'h1011);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            sw    = ($urandom_range(0, 3) != 0);
            nl    = $urandom_range(0, 3);
            simul = 1'($urandom_range(0, 1));
            frameStart(sw, -1);
            for (int l = 0; l < nl; l++) begin
                case ($urandom_range(0, 3))
                    0:       len = 2 * H;
                    1:       len = 2 * H - 1;
                    2:       len = 2 * H + 1;
                    default: len = $urandom_range(1, 12);
                endcase
                sendLine(len, -1, simul && (l == nl - 1), -1);
            end
            frameEnd(simul && (nl > 0), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
